// File: rtl/imem_responder.sv
// Instruction memory with a combinational fetch port and a byte-serial program loader.
// Define IMEM_MISALIGN_TRAP_EN to return NOP on misaligned fetches and flag them on o_misalign.
module imem_responder #(
   parameter int                    P_DATA_WIDTH = 32,
   parameter int                    PC_WIDTH     = 9,
   parameter logic [P_DATA_WIDTH-1:0] P_NOP      = 32'h0000_0013
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [PC_WIDTH:0]       i_imem_addr,
   output logic [P_DATA_WIDTH-1:0] o_imem_rdata,
   input  logic                    i_load_start,
   input  logic                    i_load_valid,
   input  logic [7:0]              i_load_byte,
   input  logic                    i_load_last,
   output logic                    o_load_ready,
   output logic                    o_loading,
   output logic                    o_load_done,
   output logic                    o_load_err,
`ifdef IMEM_MISALIGN_TRAP_EN
   output logic                    o_misalign,
`endif
   output logic [PC_WIDTH-1:0]     o_word_count
);

   localparam int DEPTH = 2 ** (PC_WIDTH - 2);
   localparam logic [PC_WIDTH-1:0] PTR_ONE = 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [P_DATA_WIDTH-1:0] mem [DEPTH];

   logic [1:0]              state_q, state_d;
   logic [1:0]              idx_q, idx_d;
   logic [PC_WIDTH-1:0]     ptr_q, ptr_d;
   logic [P_DATA_WIDTH-1:0] buf_q, buf_d;
   logic                    last_q, last_d;
   logic                    err_q, err_d;
   logic [PC_WIDTH-1:0]     cnt_q, cnt_d;
   logic                    mem_we;
   logic                    ptr_full;
   logic                    loading;

   // The pointer saturates at DEPTH, so either top bit set means the array is full.
   assign ptr_full = |ptr_q[PC_WIDTH-1:PC_WIDTH-2];
   assign loading  = (state_q == S_LOAD) || (state_q == S_COMMIT);

   assign o_load_ready = (state_q == S_LOAD);
   assign o_loading    = loading;
   assign o_load_done  = (state_q == S_DONE);
   assign o_load_err   = err_q;
   assign o_word_count = cnt_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      buf_d   = buf_q;
      last_d  = last_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_load_start) begin
               state_d = S_LOAD;
               ptr_d   = '0;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (i_load_valid) begin
               buf_d[8*idx_q +: 8] = i_load_byte;
               idx_d               = idx_q + 2'd1;
               last_d              = i_load_last;
               if (idx_q == 2'd3 || i_load_last) state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            if (!ptr_full) begin
               mem_we = 1'b1;
               ptr_d  = ptr_q + PTR_ONE;
            end else begin
               err_d = 1'b1;
            end
            buf_d   = '0;
            idx_d   = '0;
            last_d  = 1'b0;
            state_d = last_q ? S_DONE : S_LOAD;
         end
         S_DONE: begin
            cnt_d   = ptr_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         buf_q   <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         buf_q   <= buf_d;
         last_q  <= last_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the array has no reset so it maps onto RAM and survives a mid-load reset.
   always_ff @(posedge i_clk) begin
      if (mem_we) mem[ptr_q[PC_WIDTH-3:0]] <= buf_q;
   end

   // Word indices beyond the array depth read as NOP rather than aliasing.
   always_comb begin
      o_imem_rdata = P_NOP;
      if (!loading && !i_imem_addr[PC_WIDTH]) o_imem_rdata = mem[i_imem_addr[PC_WIDTH-1:2]];
`ifdef IMEM_MISALIGN_TRAP_EN
      if (i_imem_addr[1:0] != 2'b00) o_imem_rdata = P_NOP;
`endif
   end

`ifdef IMEM_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   always_comb begin
      misalign_d = misalign_q;
      if (!loading && i_imem_addr[1:0] != 2'b00) misalign_d = 1'b1;
      if (i_load_start) misalign_d = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) misalign_q <= 1'b0;
      else          misalign_q <= misalign_d;
   end

   assign o_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder: loads, partial words, overflow, reset mid-load.
module tb_imem_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [9:0]  i_imem_addr;
   logic [31:0] o_imem_rdata;
   logic        i_load_start, i_load_valid, i_load_last;
   logic [7:0]  i_load_byte;
   logic        o_load_ready, o_loading, o_load_done, o_load_err;
   logic [8:0]  o_word_count;
`ifdef IMEM_MISALIGN_TRAP_EN
   logic        o_misalign;
`endif

   int n_cmp = 0;
   int n_mis = 0;
   int done_cnt = 0;

   imem_responder dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_imem_addr  (i_imem_addr),
      .o_imem_rdata (o_imem_rdata),
      .i_load_start (i_load_start),
      .i_load_valid (i_load_valid),
      .i_load_byte  (i_load_byte),
      .i_load_last  (i_load_last),
      .o_load_ready (o_load_ready),
      .o_loading    (o_loading),
      .o_load_done  (o_load_done),
      .o_load_err   (o_load_err),
`ifdef IMEM_MISALIGN_TRAP_EN
      .o_misalign   (o_misalign),
`endif
      .o_word_count (o_word_count)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) if (o_load_done) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic start_load();
      @(negedge i_clk);
      i_load_start = 1'b1;
      @(negedge i_clk);
      i_load_start = 1'b0;
   endtask

   // Present one byte until accepted; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input logic last);
      int t = 0;
      i_load_byte  = b;
      i_load_last  = last;
      i_load_valid = 1'b1;
      while (!o_load_ready && t < 20) begin
         @(negedge i_clk);
         t++;
      end
      if (t >= 20) check("ready_timeout", 32'd0, 32'd1);
      @(negedge i_clk);
      i_load_valid = 1'b0;
      i_load_last  = 1'b0;
   endtask

   task automatic set_addr(input logic [9:0] a);
      i_imem_addr = a;
      #1;
   endtask

   logic [7:0] img1 [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h00, 8'hA0, 8'h00};
   logic [7:0] img5 [6] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
   logic [7:0] img6 [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

   initial begin
      i_rst_n      = 1'b0;
      i_imem_addr  = '0;
      i_load_start = 1'b0;
      i_load_valid = 1'b0;
      i_load_last  = 1'b0;
      i_load_byte  = '0;
      #1;
      check("rst_ready", o_load_ready, 0);
      check("rst_loading", o_loading, 0);
      check("rst_done", o_load_done, 0);
      check("rst_err", o_load_err, 0);
      check("rst_count", o_word_count, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Two full words.
      start_load();
      check("ld1_loading", o_loading, 1);
      check("ld1_ready", o_load_ready, 1);
      check("ld1_nop_load", o_imem_rdata, NOP);
      for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
      check("ld1_commit_ready", o_load_ready, 0);
      check("ld1_commit_nop", o_imem_rdata, NOP);
      @(negedge i_clk);
      check("ld1_done_pulse", o_load_done, 1);
      check("ld1_done_loading", o_loading, 0);
      @(negedge i_clk);
      check("ld1_done_low", o_load_done, 0);
      check("ld1_word0", o_imem_rdata, 32'h0010_0513);
      check("ld1_count", o_word_count, 2);
      check("ld1_err", o_load_err, 0);
      check("ld1_done_cnt", done_cnt, 1);
      set_addr(10'h004);
      check("ld1_word1", o_imem_rdata, 32'h00A0_00B3);

      // Bytes offered while idle are not consumed.
      i_load_byte  = 8'hFF;
      i_load_valid = 1'b1;
      repeat (3) @(negedge i_clk);
      i_load_valid = 1'b0;
      check("idle_valid_ready", o_load_ready, 0);
      check("idle_valid_count", o_word_count, 2);
      check("idle_valid_word1", o_imem_rdata, 32'h00A0_00B3);

      // Partial word with gaps; a start pulse mid-load must be ignored.
      set_addr(10'h000);
      start_load();
      send_byte(8'h11, 1'b0);
      i_load_start = 1'b1;
      @(negedge i_clk);
      i_load_start = 1'b0;
      send_byte(8'h22, 1'b0);
      @(negedge i_clk);
      send_byte(8'h33, 1'b1);
      check("ld3_commit_ready", o_load_ready, 0);
      repeat (2) @(negedge i_clk);
      check("ld3_word0", o_imem_rdata, 32'h0033_2211);
      check("ld3_count", o_word_count, 1);
      set_addr(10'h004);
      check("ld3_word1_kept", o_imem_rdata, 32'h00A0_00B3);

      // Overflow: 129 words into a 128-word array.
      start_load();
      for (int w = 0; w <= 128; w++) begin
         if (w == 128) begin
            @(negedge i_clk);
            check("ovf_err_before", o_load_err, 0);
         end
         for (int j = 0; j < 4; j++) begin
            logic [7:0] wb;
            wb = 8'(w) ^ 8'(j);
            send_byte(wb, (w == 128) && (j == 3));
         end
      end
      @(negedge i_clk);
      check("ovf_err_after", o_load_err, 1);
      @(negedge i_clk);
      check("ovf_count", o_word_count, 128);
      set_addr(10'h000);
      check("ovf_word0", o_imem_rdata, 32'h0302_0100);
      set_addr(10'h1FC);
      check("ovf_word127", o_imem_rdata, 32'h7C7D_7E7F);

      // Reset in the middle of the second word.
      set_addr(10'h000);
      start_load();
      check("rl_err_cleared", o_load_err, 0);
      for (int i = 0; i < 6; i++) send_byte(img5[i], 1'b0);
      i_rst_n = 1'b0;
      #1;
      check("rl_loading", o_loading, 0);
      check("rl_ready", o_load_ready, 0);
      check("rl_count", o_word_count, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      check("rl_word0", o_imem_rdata, 32'hEFBE_ADDE);
      check("rl_no_done", done_cnt, 3);
      start_load();
      for (int i = 0; i < 4; i++) send_byte(img6[i], i == 3);
      repeat (2) @(negedge i_clk);
      check("rl2_word0", o_imem_rdata, 32'h1122_3344);
      check("rl2_count", o_word_count, 1);
      check("rl2_done_cnt", done_cnt, 4);

      // Misaligned fetch.
      set_addr(10'h006);
`ifdef IMEM_MISALIGN_TRAP_EN
      check("mis_nop", o_imem_rdata, NOP);
      @(negedge i_clk);
      check("mis_flag", o_misalign, 1);
      set_addr(10'h004);
      @(negedge i_clk);
      check("mis_sticky", o_misalign, 1);
`else
      check("mis_ignored", o_imem_rdata, 32'h0203_0001);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
